// File: rtl/nivel_memoria_respondedor.sv
// Line-organised backing-store responder below the last cache level: one request at a time,
// fixed access latency. Optional macro MEM_STATS_EN adds saturating read/write accept counters.
module nivel_memoria_respondedor #(
    parameter int LINES_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [88:0] D_PUSH,
    input  logic        Push_Valid,
    output logic        Push_Ready,
    output logic [87:0] D_POP,
    output logic        Pop_Valid,
    input  logic        Pop_Ack,
    output logic        Busy
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] Read_Count,
    output logic [15:0] Write_Count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          op_q, op_d;
    logic [23:0]   addr_q, addr_d;
    logic [63:0]   data_q, data_d;
    logic [87:0]   pop_q, pop_d;
    logic          pop_vld_q, pop_vld_d;
    logic          mem_we;
    logic          accept;
    logic [LINES_LOG2-1:0] idx;
    logic [63:0]   mem [0:(1<<LINES_LOG2)-1];

    assign Push_Ready = (state_q == IDLE) & ~Reset;
    assign Busy       = (state_q != IDLE);
    assign accept     = Push_Valid & Push_Ready;
    assign idx        = addr_q[LINES_LOG2+2:3];
    assign D_POP      = pop_q;
    assign Pop_Valid  = pop_vld_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        pop_d     = pop_q;
        pop_vld_d = pop_vld_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = D_PUSH[88];
                    addr_d  = D_PUSH[87:64];
                    data_d  = D_PUSH[63:0];
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 8'd0) begin
                    if (op_q) begin
                        mem_we  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pop_d     = {addr_q, mem[idx]};
                        pop_vld_d = 1'b1;
                        state_d   = RESPOND;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESPOND: begin
                if (Pop_Ack) begin
                    pop_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            op_q      <= 1'b0;
            addr_q    <= 24'd0;
            data_q    <= 64'd0;
            pop_q     <= 88'd0;
            pop_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pop_q     <= pop_d;
            pop_vld_q <= pop_vld_d;
        end
    end

    // Store has no reset; a commit coinciding with Reset is dropped.
    always_ff @(posedge CLK) begin
        if (mem_we && !Reset) mem[idx] <= data_q;
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (accept && !D_PUSH[88] && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (accept &&  D_PUSH[88] && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign Read_Count  = rd_cnt_q;
    assign Write_Count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_nivel_memoria_respondedor.sv
// Randomised bench for nivel_memoria_respondedor against an array-based memory model.
module tb_nivel_memoria_respondedor;
    localparam int LINES_LOG2 = 8;
    localparam int LATENCY    = 4;
    localparam int NL         = 1 << LINES_LOG2;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [88:0] D_PUSH = '0;
    logic        Push_Valid = 1'b0;
    logic        Push_Ready;
    logic [87:0] D_POP;
    logic        Pop_Valid;
    logic        Pop_Ack = 1'b0;
    logic        Busy;
`ifdef MEM_STATS_EN
    logic [15:0] Read_Count, Write_Count;
`endif

    nivel_memoria_respondedor #(.LINES_LOG2(LINES_LOG2), .LATENCY(LATENCY)) dut (
        .CLK(CLK), .Reset(Reset), .D_PUSH(D_PUSH), .Push_Valid(Push_Valid),
        .Push_Ready(Push_Ready), .D_POP(D_POP), .Pop_Valid(Pop_Valid),
        .Pop_Ack(Pop_Ack), .Busy(Busy)
`ifdef MEM_STATS_EN
        , .Read_Count(Read_Count), .Write_Count(Write_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] ref_mem [NL];
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic int ix(input logic [23:0] a);
        return int'(a / 24'd8) % NL;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!Push_Ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 96'(0), 96'(1));
    endtask

    // Returns at the first negedge after the acceptance edge.
    task automatic issue(input logic op, input logic [23:0] a, input logic [63:0] d);
        wait_ready();
        D_PUSH     = {op, a, d};
        Push_Valid = 1'b1;
        @(negedge CLK);
        Push_Valid = 1'b0;
        D_PUSH     = 89'({$urandom, $urandom, $urandom});
        if (op) wr_cnt++; else rd_cnt++;
    endtask

    task automatic wait_done(input string tag, input logic is_rd);
        int n = 1;
        while (!(is_rd ? Pop_Valid : Push_Ready) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 96'(n - 1), 96'(LATENCY));
    endtask

    task automatic do_write(input logic [23:0] a, input logic [63:0] d);
        issue(1'b1, a, d);
        ref_mem[ix(a)] = d;
        wait_done("wr_lat", 1'b0);
    endtask

    task automatic do_read(input logic [23:0] a, input int hold, input logic push_on_ack,
                           input logic [23:0] pa, input logic [63:0] pd);
        logic [87:0] exp;
        issue(1'b0, a, 64'd0);
        exp = {a, ref_mem[ix(a)]};
        wait_done("rd_lat", 1'b1);
        chk("rd_data", 96'(D_POP), 96'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("hold_vld", 96'(Pop_Valid), 96'(1));
            chk("hold_data", 96'(D_POP), 96'(exp));
            chk("hold_rdy", 96'(Push_Ready), 96'(0));
        end
        Pop_Ack = 1'b1;
        if (push_on_ack) begin
            D_PUSH     = {1'b1, pa, pd};
            Push_Valid = 1'b1;
            #1 chk("ack_rdy_low", 96'(Push_Ready), 96'(0));
        end
        @(negedge CLK);
        Pop_Ack = 1'b0;
        chk("ack_clr", 96'(Pop_Valid), 96'(0));
        if (push_on_ack) begin
            chk("ack_push_not_taken", 96'({Busy, Push_Ready}), 96'(2'b01));
            @(negedge CLK);
            Push_Valid = 1'b0;
            wr_cnt++;
            ref_mem[ix(pa)] = pd;
            chk("push_taken_next", 96'(Busy), 96'(1));
            wait_ready();
        end else begin
            chk("ack_rdy", 96'(Push_Ready), 96'(1));
        end
    endtask

    task automatic pulse_reset(input int cyc);
        Reset = 1'b1;
        repeat (cyc) @(negedge CLK);
        Reset = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    initial begin
        logic        ok;
        logic [23:0] a;
        // Reset and idle outputs
        @(negedge CLK);
        chk("rst_rdy_low", 96'(Push_Ready), 96'(0));
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("rst_rdy", 96'(Push_Ready), 96'(1));
        chk("rst_vld", 96'(Pop_Valid), 96'(0));
        chk("rst_dpop", 96'(D_POP), 96'(0));
        chk("rst_busy", 96'(Busy), 96'(0));
        @(negedge CLK);

        // Preload every line so the model is fully known
        for (int i = 0; i < NL; i++) do_write(24'(i * 8), rnd64());

        // Write then read, with held response and ack+push collision
        do_write(24'h000018, 64'hDEADBEEF_01234567);
        do_read(24'h000018, 10, 1'b1, 24'h000020, 64'h0BAD_F00D_1234_5678);
        do_read(24'h000020, 0, 1'b0, 24'h0, 64'h0);

        // Aliasing: bit 11 lies above the index
        do_write(24'h000008, 64'h1);
        do_read(24'h000808, 0, 1'b0, 24'h0, 64'h0);
        chk("alias_val", 96'(D_POP), 96'({24'h000808, 64'h1}));

        // Ack while no response pending is ignored
        Pop_Ack = 1'b1;
        @(negedge CLK);
        Pop_Ack = 1'b0;
        chk("stray_ack", 96'({Busy, Pop_Valid, Push_Ready}), 96'(3'b001));

        // Reset in the second ACCESS cycle of a write
        issue(1'b1, 24'h000010, 64'hAA);
        @(negedge CLK);
        pulse_reset(1);
        #1 chk("midwr_rdy", 96'({Busy, Push_Ready}), 96'(2'b01));
        @(negedge CLK);
        do_read(24'h000010, 0, 1'b0, 24'h0, 64'h0);

        // Reset while a read is in flight discards the response
        issue(1'b0, 24'h000040, 64'h0);
        pulse_reset(1);
        ok = 1'b1;
        for (int i = 0; i < LATENCY + 2; i++) begin
            if (Pop_Valid || D_POP != 88'd0) ok = 1'b0;
            @(negedge CLK);
        end
        chk("midrd_no_resp", 96'(ok), 96'(1));

        // Randomised traffic
        for (int k = 0; k < 60; k++) begin
            a = 24'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, rnd64());
            else do_read(a, int'($urandom_range(0, 3)), 1'b0, 24'h0, 64'h0);
            if ($urandom_range(0, 3) == 0) begin
                Pop_Ack = 1'b1;
                @(negedge CLK);
                Pop_Ack = 1'b0;
            end
        end

`ifdef MEM_STATS_EN
        pulse_reset(1);
        for (int i = 0; i < 3; i++) do_write(24'(i * 8), rnd64());
        for (int i = 0; i < 2; i++) do_read(24'(i * 8), 0, 1'b0, 24'h0, 64'h0);
        chk("wr_count", 96'(Write_Count), 96'(wr_cnt));
        chk("rd_count", 96'(Read_Count), 96'(rd_cnt));
        chk("wr_count3", 96'(Write_Count), 96'(3));
        chk("rd_count2", 96'(Read_Count), 96'(2));
        pulse_reset(2);
        #1;
        chk("cnt_rst", 96'({Write_Count, Read_Count}), 96'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
